inst_decode_stage: RTL and testbench

- Parametrised successor to the RV32I decode stage.
- Decodes all RV32I base formats (R/I/S/B/U/J) to XLEN-wide operands.
- Holds one instruction in an input pipeline register and uses a valid/ready handshake on both sides.
- Selects forwarded operands from NUM_FWD later stages with fixed priority, interlocks on pending (not yet computed) results, and supports a flush from the execute-stage redirect.

---
 rtl/inst_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_inst_decode_stage.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// Instruction decode stage for the RV32I/RV64I base integer set.
// Holds one instruction in an input register and uses valid/ready handshakes
// on the fetch and execute sides. Source operands are taken from the youngest
// matching forwarding source, or from the register file if none matches.
// The stage interlocks on results that are not yet computed.
// A flush from the execute-stage redirect discards the held instruction.
module inst_decode_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_inst,
    output logic [4:0]              rs1_num,
    output logic [4:0]              rs2_num,
    input  logic [XLEN-1:0]         rs1_rf,
    input  logic [XLEN-1:0]         rs2_rf,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_busy,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [4:0]              out_rd,
    output logic                    out_rd_we,
    output logic [XLEN-1:0]         out_src1,
    output logic [XLEN-1:0]         out_src2,
    output logic [XLEN-1:0]         out_imm,
    output logic [3:0]              out_alu_op,
    output logic [2:0]              out_kind,
    output logic [2:0]              out_funct3,
    output logic                    out_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JAL    = 3'd4,
        KIND_JALR   = 3'd5,
        KIND_LUI    = 3'd6,
        KIND_AUIPC  = 3'd7
    } kind_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam bit IS_RV64 = (XLEN == 64);

    // Sign-extend a 32-bit immediate to the operand width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ALU operation selected by funct3 alone (the funct7 = 0x00 encodings).
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic            held_valid;
    logic [XLEN-1:0] held_pc;
    logic [31:0]     held_inst;
    logic            accept;
    logic            retire;
    logic            hazard;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode  = held_inst[6:0];
    assign rd      = held_inst[11:7];
    assign funct3  = held_inst[14:12];
    assign funct7  = held_inst[31:25];
    assign rs1_num = held_inst[19:15];
    assign rs2_num = held_inst[24:20];

    // Format immediates, all sign-extended from inst[31].
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign imm_i = sext32({{20{held_inst[31]}}, held_inst[31:20]});
    assign imm_s = sext32({{20{held_inst[31]}}, held_inst[31:25], held_inst[11:7]});
    assign imm_b = sext32({{19{held_inst[31]}}, held_inst[31], held_inst[7],
                           held_inst[30:25], held_inst[11:8], 1'b0});
    assign imm_u = sext32({held_inst[31:12], 12'b0});
    assign imm_j = sext32({{11{held_inst[31]}}, held_inst[31], held_inst[19:12],
                           held_inst[20], held_inst[30:21], 1'b0});

    // RV64 widens shamt into inst[25], leaving six funct bits above it.
    logic shift_hi_zero;
    logic shift_hi_sra;

    assign shamt         = IS_RV64 ? XLEN'(held_inst[25:20]) : XLEN'(held_inst[24:20]);
    assign shift_hi_zero = IS_RV64 ? (held_inst[31:26] == 6'b000000) : (funct7 == 7'h00);
    assign shift_hi_sra  = IS_RV64 ? (held_inst[31:26] == 6'b010000) : (funct7 == 7'h20);

    kind_e           kind;
    alu_op_e         alu_op;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            writes_rd;
    logic            src2_is_imm;

    // Decode opcode/funct fields into kind, ALU op, immediate and legality.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a variable unassigned (latch).
        kind        = KIND_ALU;
        alu_op      = ALU_ADD;
        imm         = '0;
        illegal     = 1'b0;
        writes_rd   = 1'b1;
        src2_is_imm = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00)                         alu_op = base_alu(funct3);
                else if (funct7 == 7'h20 && funct3 == 3'b000) alu_op = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101) alu_op = ALU_SRA;
                else                                          illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                src2_is_imm = 1'b1;
                if (funct3 == 3'b001) begin
                    imm     = shamt;
                    alu_op  = ALU_SLL;
                    illegal = !shift_hi_zero;
                end else if (funct3 == 3'b101) begin
                    imm = shamt;
                    if (shift_hi_zero)     alu_op  = ALU_SRL;
                    else if (shift_hi_sra) alu_op  = ALU_SRA;
                    else                   illegal = 1'b1;
                end else begin
                    // funct3 = 000 is always ADDI; there is no immediate subtract.
                    imm    = imm_i;
                    alu_op = base_alu(funct3);
                end
            end
            OPC_LOAD: begin
                kind = KIND_LOAD;
                imm  = imm_i;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
                    3'b011, 3'b110:                         illegal = !IS_RV64;
                    default:                                illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                kind      = KIND_STORE;
                imm       = imm_s;
                writes_rd = 1'b0;
                case (funct3)
                    3'b000, 3'b001, 3'b010: illegal = 1'b0;
                    3'b011:                 illegal = !IS_RV64;
                    default:                illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                kind      = KIND_BRANCH;
                imm       = imm_b;
                writes_rd = 1'b0;
                case (funct3)
                    3'b000, 3'b001: alu_op  = ALU_SUB;
                    3'b100, 3'b101: alu_op  = ALU_SLT;
                    3'b110, 3'b111: alu_op  = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                kind        = KIND_LUI;
                imm         = imm_u;
                alu_op      = ALU_PASSB;
                src2_is_imm = 1'b1;
            end
            OPC_AUIPC: begin
                kind = KIND_AUIPC;
                imm  = imm_u;
            end
            OPC_JAL: begin
                kind = KIND_JAL;
                imm  = imm_j;
            end
            OPC_JALR: begin
                kind    = KIND_JALR;
                imm     = imm_i;
                illegal = (funct3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase

        // Illegal instructions still flow to EX as a harmless ALU op so it can trap.
        if (illegal) begin
            kind      = KIND_ALU;
            alu_op    = ALU_ADD;
            writes_rd = 1'b0;
            imm       = '0;
        end
    end

    logic uses_rs1;
    logic uses_rs2;

    assign uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    logic            rs1_hit, rs1_busy, rs2_hit, rs2_busy;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    // Find the youngest forwarding source per operand; scanning from the oldest
    // down lets the lowest matching index overwrite any older match.
    always_comb begin
        rs1_hit  = 1'b0;
        rs1_busy = 1'b0;
        rs1_fwd  = '0;
        rs2_hit  = 1'b0;
        rs2_busy = 1'b0;
        rs2_fwd  = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs1_num)) begin
                rs1_hit  = 1'b1;
                rs1_busy = fwd_busy[i];
                rs1_fwd  = fwd_data[i*XLEN +: XLEN];
            end
            if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs2_num)) begin
                rs2_hit  = 1'b1;
                rs2_busy = fwd_busy[i];
                rs2_fwd  = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rs1_val = (rs1_num == 5'd0) ? '0 : (rs1_hit ? rs1_fwd : rs1_rf);
    assign rs2_val = (rs2_num == 5'd0) ? '0 : (rs2_hit ? rs2_fwd : rs2_rf);

    // A used operand whose youngest producer has not computed its result stalls.
    assign hazard = (uses_rs1 && rs1_num != 5'd0 && rs1_hit && rs1_busy)
                 || (uses_rs2 && rs2_num != 5'd0 && rs2_hit && rs2_busy);

    assign out_valid = held_valid && !hazard;
    assign retire    = out_valid && out_ready;
    assign in_ready  = !flush && (!held_valid || retire);
    assign accept    = in_valid && in_ready;

    assign out_pc      = held_pc;
    assign out_rd      = rd;
    assign out_rd_we   = writes_rd && (rd != 5'd0);
    assign out_src1    = rs1_val;
    assign out_src2    = src2_is_imm ? imm : rs2_val;
    assign out_imm     = imm;
    assign out_alu_op  = alu_op;
    assign out_kind    = kind;
    assign out_funct3  = funct3;
    assign out_illegal = illegal;

    // Occupancy of the one-entry instruction register; flush beats everything.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers are written with non-blocking assignments so all
        // state updates at an edge see the values from before that edge.
        if (!rst) begin
            held_valid <= 1'b0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (accept) begin
            held_valid <= 1'b1;
        end else if (retire) begin
            held_valid <= 1'b0;
        end
    end

    // Capture the offered PC and instruction word on accept.
    always_ff @(posedge clk) begin
        // NOTE: the payload is deliberately left out of reset; held_valid
        // alone decides whether these bits mean anything.
        if (accept) begin
            held_pc   <= in_pc;
            held_inst <= in_inst;
        end
    end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage (XLEN=32, two forwarding sources).
// Directed scenarios cover reset, forwarding priority, load-use interlock,
// back-pressure, flush and async reset. Randomized instructions follow, each
// checked against a decode/forwarding reference model.
module tb_inst_decode_stage;

    localparam int XLEN = 32;
    localparam int NF   = 2;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3;
    localparam int K_JAL = 4, K_JALR = 5, K_LUI = 6, K_AUIPC = 7;
    localparam int A_ADD = 0, A_SUB = 1, A_SRA = 7, A_PASSB = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_inst;
    logic [4:0]      rs1_num, rs2_num;
    logic [31:0]     rs1_rf, rs2_rf;
    logic [NF-1:0]   fwd_valid, fwd_busy;
    logic [5*NF-1:0] fwd_rd;
    logic [32*NF-1:0] fwd_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic [31:0]     out_src1, out_src2, out_imm;
    logic [3:0]      out_alu_op;
    logic [2:0]      out_kind, out_funct3;
    logic            out_illegal;

    // Bench-side view of the forwarding sources and register file.
    logic        fv   [NF];
    logic        fb   [NF];
    logic [4:0]  frd  [NF];
    logic [31:0] fdat [NF];
    logic [31:0] rf_mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    inst_decode_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rs1_rf(rs1_rf), .rs2_rf(rs2_rf),
        .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_src1(out_src1), .out_src2(out_src2),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_kind(out_kind),
        .out_funct3(out_funct3), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    assign rs1_rf = rf_mem[rs1_num];
    assign rs2_rf = rf_mem[rs2_num];

    always_comb begin
        fwd_valid = '0;
        fwd_busy  = '0;
        fwd_rd    = '0;
        fwd_data  = '0;
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]        = fv[i];
            fwd_busy[i]         = fb[i];
            fwd_rd[i*5 +: 5]    = frd[i];
            fwd_data[i*32 +: 32] = fdat[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NF; i++) begin
            fv[i]   = 1'b0;
            fb[i]   = 1'b0;
            frd[i]  = 5'd0;
            fdat[i] = 32'd0;
        end
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          illegal;
        int          kind;
        int          alu;
        bit          alu_known;
        bit          rd_we;
        logic [31:0] imm;
        bit          use1;
        bit          use2;
        bit          src2_imm;
    } ref_t;

    // ALU op for funct3 with funct7 = 0, straight from the encoding table.
    function automatic int plain_alu(input logic [2:0] f3);
        int table_op [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        return table_op[f3];
    endfunction

    function automatic ref_t model(input logic [31:0] w);
        ref_t r;
        int   s;
        logic [2:0] f3;
        logic [6:0] f7;
        s  = int'(w);
        f3 = w[14:12];
        f7 = w[31:25];
        r  = '{illegal: 0, kind: K_ALU, alu: A_ADD, alu_known: 0, rd_we: 0,
               imm: 32'd0, use1: 1, use2: 0, src2_imm: 0};
        case (w[6:0])
            7'h33: begin
                r.use2 = 1; r.alu_known = 1;
                if (f7 == 7'h00)                      r.alu = plain_alu(f3);
                else if (f7 == 7'h20 && f3 == 3'd0)   r.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)   r.alu = A_SRA;
                else                                  r.illegal = 1;
            end
            7'h13: begin
                r.src2_imm = 1; r.alu_known = 1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    r.imm = 32'(int'(w[24:20]));
                    if (f7 == 7'h00)                    r.alu = plain_alu(f3);
                    else if (f3 == 3'd5 && f7 == 7'h20) r.alu = A_SRA;
                    else                                r.illegal = 1;
                end else begin
                    r.imm = 32'(s >>> 20);
                    r.alu = plain_alu(f3);
                end
            end
            7'h03: begin
                r.kind = K_LOAD; r.imm = 32'(s >>> 20);
                r.illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            7'h23: begin
                r.kind = K_STORE; r.use2 = 1;
                r.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
                r.illegal = !(f3 inside {3'd0, 3'd1, 3'd2});
            end
            7'h63: begin
                r.kind = K_BRANCH; r.use2 = 1;
                r.imm = 32'((s >>> 31) * 4096 + int'(w[7]) * 2048
                            + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
                r.illegal = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h37: begin
                r.kind = K_LUI; r.use1 = 0; r.imm = w & 32'hFFFF_F000;
                r.src2_imm = 1; r.alu = A_PASSB; r.alu_known = 1;
            end
            7'h17: begin
                r.kind = K_AUIPC; r.use1 = 0; r.imm = w & 32'hFFFF_F000;
            end
            7'h6F: begin
                r.kind = K_JAL; r.use1 = 0;
                r.imm = 32'((s >>> 31) * 1048576 + int'(w[19:12]) * 4096
                            + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            end
            7'h67: begin
                r.kind = K_JALR; r.imm = 32'(s >>> 20); r.illegal = (f3 != 3'd0);
            end
            default: r.illegal = 1;
        endcase
        if (r.illegal) r.kind = K_ALU;
        r.rd_we = !r.illegal && (w[11:7] != 5'd0)
                  && (r.kind != K_STORE) && (r.kind != K_BRANCH);
        return r;
    endfunction

    // Value an operand must resolve to: x0 is zero, youngest valid match wins.
    function automatic logic [31:0] resolve(input logic [4:0] reg_num);
        if (reg_num == 5'd0) return 32'd0;
        for (int i = 0; i < NF; i++)
            if (fv[i] && frd[i] == reg_num) return fdat[i];
        return rf_mem[reg_num];
    endfunction

    // True when the youngest matching source for this register is still busy.
    function automatic bit pending(input logic [4:0] reg_num);
        if (reg_num == 5'd0) return 1'b0;
        for (int i = 0; i < NF; i++)
            if (fv[i] && frd[i] == reg_num) return fb[i];
        return 1'b0;
    endfunction

    function automatic bit model_hazard(input logic [31:0] w);
        ref_t r;
        r = model(w);
        return (r.use1 && pending(w[19:15])) || (r.use2 && pending(w[24:20]));
    endfunction

    task automatic check_fields(input string pfx, input logic [31:0] pc, input logic [31:0] w);
        ref_t r;
        r = model(w);
        check({pfx, " pc"}, out_pc, pc);
        check({pfx, " rd"}, out_rd, w[11:7]);
        check({pfx, " funct3"}, out_funct3, w[14:12]);
        check({pfx, " illegal"}, out_illegal, r.illegal);
        check({pfx, " rd_we"}, out_rd_we, r.rd_we);
        check({pfx, " kind"}, out_kind, r.kind);
        if (!r.illegal) check({pfx, " imm"}, out_imm, r.imm);
        if (!r.illegal && r.alu_known) check({pfx, " alu_op"}, out_alu_op, r.alu);
        if (r.use1) check({pfx, " src1"}, out_src1, resolve(w[19:15]));
        if (!r.illegal && r.src2_imm) check({pfx, " src2 imm"}, out_src2, r.imm);
        else if (!r.illegal && r.use2) check({pfx, " src2 reg"}, out_src2, resolve(w[24:20]));
    endtask

    function automatic logic [31:0] random_inst();
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [6:0] odd_opc [3] = '{7'h7F, 7'h0B, 7'h5B};
        int sel;
        sel = int'($urandom_range(0, 9));
        f3  = 3'($urandom);
        f7  = 7'($urandom);
        case (sel)
            0: opc = 7'h33;
            1: opc = 7'h13;
            2: opc = 7'h03;
            3: opc = 7'h23;
            4: opc = 7'h63;
            5: opc = 7'h37;
            6: opc = 7'h17;
            7: opc = 7'h6F;
            8: begin opc = 7'h67; f3 = 3'd0; end
            default: opc = odd_opc[$urandom_range(0, 2)];
        endcase
        if (sel <= 1) begin
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
        end
        return {f7, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), f3,
                5'($urandom_range(0, 4)), opc};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] pc;
        bit          hz;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        out_ready = 1'b1;
        clear_fwd();
        for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;

        // Reset state
        sample();
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        step();
        rst = 1'b1;
        sample();
        check("post-reset out_valid", out_valid, 1'b0);
        check("post-reset in_ready", in_ready, 1'b1);

        // ADDI x1,x0,-1
        step();
        rf_mem[0] = 32'hDEAD_BEEF;
        offer(32'h0000_1000, 32'hFFF0_0093);
        sample();
        check("addi in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        sample();
        check("addi out_valid", out_valid, 1'b1);
        check("addi src1", out_src1, 32'h0);
        check("addi src2", out_src2, 32'hFFFF_FFFF);
        check("addi imm", out_imm, 32'hFFFF_FFFF);
        check("addi rd", out_rd, 5'd1);
        check("addi rd_we", out_rd_we, 1'b1);
        check("addi alu_op", out_alu_op, A_ADD);

        // ADD x3,x1,x2 with forwarding priority
        step();
        out_ready = 1'b0;
        offer(32'h0000_1004, 32'h0020_81B3);
        step();
        in_valid = 1'b0;
        rf_mem[1] = 32'h111; rf_mem[2] = 32'd4;
        fv[0] = 1; frd[0] = 5'd1; fdat[0] = 32'd5;
        fv[1] = 1; frd[1] = 5'd2; fdat[1] = 32'd9;
        sample();
        check("add src1 fwd0", out_src1, 32'd5);
        check("add src2 fwd1", out_src2, 32'd9);
        #1;
        frd[1] = 5'd1; fdat[1] = 32'd7;
        #1;
        check("add src1 fwd0 over fwd1", out_src1, 32'd5);
        check("add src2 regfile", out_src2, 32'd4);
        clear_fwd();
        out_ready = 1'b1;

        // Load-use: SW x2,8(x1) stalls on busy x2
        step();
        offer(32'h0000_1008, 32'h0020_A423);
        step();
        in_valid = 1'b0;
        rf_mem[1] = 32'h1000;
        fv[0] = 1; fb[0] = 1; frd[0] = 5'd2; fdat[0] = 32'hAA;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("lduse stall out_valid", out_valid, 1'b0);
            check("lduse stall in_ready", in_ready, 1'b0);
            step();
        end
        fb[0] = 0; fdat[0] = 32'h55;
        sample();
        check("lduse out_valid", out_valid, 1'b1);
        check("lduse src2", out_src2, 32'h55);
        check("lduse src1", out_src1, 32'h1000);
        check("lduse imm", out_imm, 32'd8);
        check("lduse kind", out_kind, K_STORE);
        step();
        clear_fwd();

        // Back-pressure: A held four cycles while B is offered
        out_ready = 1'b0;
        offer(32'h0000_0100, 32'h0010_0293);
        sample();
        check("bp accept A", in_ready, 1'b1);
        step();
        offer(32'h0000_0104, 32'h0020_0313);
        for (int c = 0; c < 4; c++) begin
            sample();
            check("bp in_ready", in_ready, 1'b0);
            check("bp out_pc", out_pc, 32'h100);
            check("bp out_valid", out_valid, 1'b1);
            step();
        end
        out_ready = 1'b1;
        sample();
        check("bp release in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        sample();
        check("bp B valid", out_valid, 1'b1);
        check("bp B pc", out_pc, 32'h104);
        check("bp B rd", out_rd, 5'd6);
        step();
        sample();
        check("bp no duplicate", out_valid, 1'b0);

        // Flush while holding BEQ x0,x0,-4
        step();
        out_ready = 1'b0;
        offer(32'h0000_0200, 32'hFE00_0EE3);
        step();
        in_valid = 1'b0;
        sample();
        check("beq imm", out_imm, 32'hFFFF_FFFC);
        check("beq kind", out_kind, K_BRANCH);
        check("beq rd_we", out_rd_we, 1'b0);
        #1;
        flush = 1'b1;
        offer(32'h0000_0300, 32'h0010_0293);
        #1;
        check("flush in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        sample();
        check("flush out_valid", out_valid, 1'b0);
        check("flush in_ready after", in_ready, 1'b1);
        step();
        sample();
        check("flush offer dropped", out_valid, 1'b0);

        // Illegal opcode, then asynchronous reset mid-cycle
        step();
        offer(32'h0000_0400, 32'h0000_00FF);
        step();
        in_valid = 1'b0;
        sample();
        check("illegal out_valid", out_valid, 1'b1);
        check("illegal flag", out_illegal, 1'b1);
        check("illegal rd_we", out_rd_we, 1'b0);
        check("illegal kind", out_kind, K_ALU);
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 1'b0);
        check("async rst in_ready", in_ready, 1'b1);
        #1;
        rst = 1'b1;
        sample();
        check("after async rst out_valid", out_valid, 1'b0);

        // Randomized instructions against the reference model
        out_ready = 1'b1;
        for (int it = 0; it < 250; it++) begin
            step();
            clear_fwd();
            for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
            w  = random_inst();
            pc = $urandom & 32'hFFFF_FFFC;
            offer(pc, w);
            sample();
            check("rnd in_ready", in_ready, 1'b1);
            step();
            in_valid = 1'b0;
            for (int i = 0; i < NF; i++) begin
                fv[i]   = 1'($urandom);
                fb[i]   = ($urandom_range(0, 3) == 0);
                frd[i]  = 5'($urandom_range(0, 4));
                fdat[i] = $urandom;
            end
            sample();
            hz = model_hazard(w);
            check("rnd out_valid", out_valid, !hz);
            if (hz) begin
                step();
                for (int i = 0; i < NF; i++) fb[i] = 1'b0;
                sample();
                check("rnd out_valid after stall", out_valid, 1'b1);
            end
            check_fields("rnd", pc, w);
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
